// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
// The receiver synchronises rxd, qualifies the start bit at its midpoint and
// samples each data bit one bit period later. It checks the stop bit and
// presents each byte on a valid/ready output register.
// The byte is committed at the stop-bit midpoint and the FSM returns to IDLE
// at that point, so back-to-back frames need no extra idle time.
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    // Clocks per bit; must be >= 4 so the half-bit load value is non-negative.
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       r_sync;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    // Next-state values and one-cycle strobes from the FSM
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_rxs;
    logic             w_expired;
    logic             w_stop_ok;
    logic             w_stop_bad;
    logic             w_can_take;

    assign w_rxs      = r_sync[1];
    assign w_expired  = (r_cnt == '0);
    // The output register can accept a new byte if it is empty or is being
    // drained in this same cycle.
    assign w_can_take = !r_valid || ready;

    // Two-flop synchroniser for the asynchronous line; it presets to idle-high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    // FSM state, bit counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state logic, counter updates and stop-bit outcome strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_stop_ok     = 1'b0;
        w_stop_bad    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A falling edge loads a half-bit delay so the start bit is
                // checked at its midpoint.
                if (!w_rxs) begin
                    w_cnt_nxt   = CNT_HALF;
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                if (w_expired) begin
                    if (!w_rxs) begin
                        w_cnt_nxt     = CNT_FULL;
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = S_DATA;
                    end else begin
                        // The line went high before the midpoint, so this
                        // was a glitch. Drop it quietly.
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_expired) begin
                    // Bits arrive LSB first, so shift in from the top.
                    w_shift_nxt   = {w_rxs, r_shift[7:1]};
                    w_cnt_nxt     = CNT_FULL;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_STOP: begin
                if (w_expired) begin
                    if (w_rxs) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        // Stop bit is low: report it once, then wait out any
                        // break so it cannot be decoded as more bytes.
                        w_stop_bad  = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            S_WAIT_HIGH: begin
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output holding register with valid/ready handshake and error pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= 1'b0;
            if (w_stop_ok) begin
                if (w_can_take) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    // The previous byte is still unread. Keep it and drop
                    // the new one.
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                // Data keeps its last value after it is consumed. Only the
                // flag clears.
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receiving end of the serial link driven by the xoro_top UART_TX output.
- Synchronises the asynchronous line, qualifies the start bit, samples each bit at mid-period, and presents each byte on a valid/ready output.
- Used as the host-command input path and as a loopback checker for the transmitter in test benches.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT (derived, localparam) = CLK_HZ/BAUD, integer division. Must be >= 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial input; idles high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  data holds an unconsumed byte.
- ready  input  1  consumer accepts data when valid && ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the previous byte was still held and not taken that cycle.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; data=8'h00; valid=0; frame_err=0; overrun=0.
  - Synchroniser flops preset to 1 (line idle).
  - Reset asserted mid-frame abandons the frame. No output is produced for it.
- rxd passes through a 2-flop synchroniser; rxs denotes its output. The FSM uses only rxs.
- The bit counter counts down. "Expiry" means the counter equals 0.
- IDLE: when rxs==0, load counter with CLKS_PER_BIT/2 - 1 and go to START.
- START: on expiry, sample rxs.
  - rxs==0: load counter with CLKS_PER_BIT-1, clear the bit index, go to DATA.
  - rxs==1: glitch; go to IDLE with no output.
- DATA: on each expiry, shift rxs into the shift register LSB-first and reload the counter. After the 8th bit, go to STOP.
- STOP: on expiry, sample rxs.
  - rxs==1: deliver the byte (see below) and go to IDLE.
  - rxs==0: frame_err=1 for exactly one cycle, byte discarded, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then go to IDLE. A break or stuck-low line therefore yields exactly one frame_err and no spurious bytes.
- Delivery, evaluated in the same cycle as the stop sample:
  - valid==0, or (valid && ready): data <= shift register, valid <= 1. No overrun.
  - valid && !ready: new byte dropped, data and valid unchanged, overrun=1 for one cycle.
- Handshake:
  - valid && ready with no delivery that cycle: valid <= 0 next cycle. data keeps its last value.
  - valid never drops without ready.
- Latency: valid rises at (CLKS_PER_BIT/2) + 9*CLKS_PER_BIT + 3 clocks after the rxd falling edge is first seen on a clk edge. Bench tolerance ±1 clock.
- Back-to-back frames need no idle time beyond the stop bit: IDLE is re-entered at the stop-bit midpoint.
- Baud tolerance: must receive correctly with a ±2% rate mismatch.

Test Plan:
All scenarios use CLK_HZ=1000000, BAUD=100000 (CLKS_PER_BIT=10) with ready held 1 unless stated.
1. Send 8'hA5 -> valid pulses for 1 cycle with data=8'hA5 about 98 clocks after the start edge; frame_err=0, overrun=0.
2. Send 8'h00, 8'hFF, 8'h55 back-to-back with no idle gap -> three deliveries in order with the same values; no errors.
3. Drive rxd low for 3 clocks, then high -> START rejects the glitch; valid, frame_err and overrun stay 0; then send 8'h3C -> received correctly.
4. Send 8'h81 with the stop bit forced low, then hold rxd low for 50 bit periods, then release and send 8'h12:
   - exactly one frame_err pulse, no valid for 8'h81;
   - next valid carries data=8'h12.
5. ready=0; send 8'h11 then 8'h22:
   - valid=1 with data=8'h11;
   - overrun pulses once at the 8'h22 stop sample, data stays 8'h11;
   - raising ready clears valid next cycle.
6. Assert reset for 1 cycle in the middle of a frame's DATA phase, then send 8'h7E:
   - no output from the aborted frame (valid=0, data=8'h00);
   - 8'h7E received correctly. Rerun scenario 1 with the sender at 102% and at 98% rate -> 8'hA5 still received.
